// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op and FSM state encodings, default latencies, and the issue-time arithmetic.
package e_mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // Full HI/LO result; divide by zero yields LO=all-ones, HI=dividend.
  // Signed divide works on magnitudes so -2^31 / -1 wraps to 32'h8000_0000 cleanly.
  function automatic mdu_res_t mdu_compute(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t    res;
    logic [63:0] prod;
    logic [31:0] ua, ub, q, r;
    logic        neg_q, neg_r;
    res   = '0;
    prod  = '0;
    ua    = a;
    ub    = b;
    q     = '0;
    r     = '0;
    neg_q = 1'b0;
    neg_r = 1'b0;
    case (op)
      MDU_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res  = prod;
      end
      MDU_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = prod;
      end
      default: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          if (op == MDU_DIV) begin
            neg_r = a[31];
            neg_q = a[31] ^ b[31];
            ua    = a[31] ? -a : a;
            ub    = b[31] ? -b : b;
          end
          q      = ua / ub;
          r      = ua % ub;
          res.lo = neg_q ? -q : q;
          res.hi = neg_r ? -r : r;
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: result computed at issue, down-counter models latency before HI/LO commit.
// Optional E_MDU_DIVZERO_HOLD_EN: divide by zero keeps prior HI/LO instead of committing the default result.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic [31:0]   p_hi, p_lo, p_hi_nxt, p_lo_nxt;
  mdu_res_t      res_c;
  logic          div_zero_c;

  assign res_c      = mdu_compute(op, A, B);
  assign div_zero_c = op[1] && (B == 32'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    hi_nxt    = HI;
    lo_nxt    = LO;
    p_hi_nxt  = p_hi;
    p_lo_nxt  = p_lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          busy_nxt  = 1'b1;
          cnt_nxt   = op[1] ? DIV_LOAD : MULT_LOAD;
`ifdef E_MDU_DIVZERO_HOLD_EN
          p_hi_nxt  = div_zero_c ? HI : res_c.hi;
          p_lo_nxt  = div_zero_c ? LO : res_c.lo;
`else
          p_hi_nxt  = res_c.hi;
          p_lo_nxt  = res_c.lo;
`endif
        end else begin
          if (mthi) hi_nxt = wdata;
          if (mtlo) lo_nxt = wdata;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          hi_nxt    = p_hi;
          lo_nxt    = p_lo;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
      p_hi  <= p_hi_nxt;
      p_lo  <= p_lo_nxt;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against a 64-bit integer arithmetic model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] HI, LO;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_hi, exp_lo;

  e_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} after an op, given the HI/LO held before it.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ph,
                                             input logic [31:0] pl);
    longint          sq, sr;
    longint unsigned uq, ur;
    if (o == 2'd0) begin
      sq = longint'($signed(a)) * longint'($signed(b));
      return 64'(sq);
    end
    if (o == 2'd1) begin
      uq = longint'(a) * longint'(b);
      return 64'(uq);
    end
    if (b == 32'd0) begin
`ifdef E_MDU_DIVZERO_HOLD_EN
      return {ph, pl};
`else
      return {a, 32'hFFFF_FFFF};
`endif
    end
    if (o == 2'd2) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      return {sr[31:0], sq[31:0]};
    end
    uq = longint'(a) / longint'(b);
    ur = longint'(a) % longint'(b);
    return {ur[31:0], uq[31:0]};
  endfunction

  // Issue one op (optionally with mtlo in the same cycle), poke ignored strobes mid-run, check latency and result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mv, input string tag);
    logic [63:0] r;
    int          n;
    int          cyc;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; mtlo = mv; wdata = 32'hDEAD_BEEF;
    r   = ref_result(o, a, b, exp_hi, exp_lo);
    cyc = o[1] ? 10 : 5;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk({tag, "_hold"}, {HI, LO}, {exp_hi, exp_lo});
      if (n == 1) begin
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678; start = 1'b1; op = 2'($urandom);
      end else begin
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(cyc));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk({tag, "_result"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  task automatic do_move(input logic h, input logic l, input logic [31:0] d, input string tag);
    @(negedge clk);
    mthi = h; mtlo = l; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
    chk({tag, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = 2'd0; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {31'd0, busy, HI, LO}, 64'd0);
    reset = 1'b1;

    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    chk("mult_neg2x3_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(2'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
    chk("divu_100_7_exact", {HI, LO}, {32'd2, 32'd14});
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    chk("div_m7_2_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_move(1'b1, 1'b0, 32'h1234_5678, "mthi_idle");
    do_move(1'b0, 1'b1, 32'h0BAD_F00D, "mtlo_idle");
    do_op(2'd1, 32'd2, 32'd3, 1'b1, "multu_with_mtlo");
    chk("multu_with_mtlo_lo", 64'(LO), 64'd6);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");

    do_move(1'b1, 1'b1, 32'hAAAA_AAAA, "mvboth");
    do_op(2'd2, 32'h0000_1234, 32'd0, 1'b0, "div_zero");
    do_move(1'b1, 1'b1, 32'hAAAA_AAAA, "mvboth2");
    do_op(2'd3, 32'hFEDC_BA98, 32'd0, 1'b0, "divu_zero");

    // Reset pulsed in the third RUN cycle of a div: aborts, never commits.
    @(negedge clk);
    start = 1'b1; op = 2'd2; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_commit", {31'd0, busy, HI, LO}, 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 200));
      rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20));
      if (ro[1] && $urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 1) == 0) rb = -rb;
      if ($urandom_range(0, 5) == 0)
        do_move(1'($urandom), 1'($urandom), $urandom, "rnd_move");
      do_op(ro, ra, rb, 1'($urandom_range(0, 3) == 0), "rnd_op");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
